// File: rtl/datapath_sequencer_if.sv
// Request/control bundle between the requester, datapath_sequencer and the 8-bit accumulator datapath.
// When DP_SEQ_STEP_EN is defined, the bundle also carries the STEP input.
interface datapath_sequencer_if #(
    parameter int ALU_CTRL_W = 4,
    parameter int SHAMT_W    = 5,
    parameter int STEP_W     = 3
);
    // START is sampled only while the sequencer is idle. OP is captured on the
    // same edge. DONE is a one-cycle pulse. START/OP are ignored while BUSY or DONE.
    logic                  START;
    logic [1:0]            OP;
`ifdef DP_SEQ_STEP_EN
    logic                  STEP;
`endif
    logic                  WE;
    logic                  SEL0;
    logic                  SEL1;
    logic                  SEL2;
    logic [ALU_CTRL_W-1:0] ALU_CTRL;
    logic [1:0]            SHIFTER_CTRL;
    logic [SHAMT_W-1:0]    SHAMT;
    logic                  REG_CLR;
    logic                  BUSY;
    logic                  DONE;
    logic [STEP_W-1:0]     CYCLE;
    logic [1:0]            fsm_state;

`ifdef DP_SEQ_STEP_EN
    modport slave (
        input  START, OP, STEP,
        output WE, SEL0, SEL1, SEL2, ALU_CTRL, SHIFTER_CTRL, SHAMT,
               REG_CLR, BUSY, DONE, CYCLE, fsm_state
    );
    modport master (
        output START, OP, STEP,
        input  WE, SEL0, SEL1, SEL2, ALU_CTRL, SHIFTER_CTRL, SHAMT,
               REG_CLR, BUSY, DONE, CYCLE, fsm_state
    );
`else
    modport slave (
        input  START, OP,
        output WE, SEL0, SEL1, SEL2, ALU_CTRL, SHIFTER_CTRL, SHAMT,
               REG_CLR, BUSY, DONE, CYCLE, fsm_state
    );
    modport master (
        output START, OP,
        input  WE, SEL0, SEL1, SEL2, ALU_CTRL, SHIFTER_CTRL, SHAMT,
               REG_CLR, BUSY, DONE, CYCLE, fsm_state
    );
`endif
endinterface

// File: rtl/datapath_sequencer.sv
// Start/done micro-sequencer for the 8-bit accumulator datapath: IDLE -> EXEC -> FIN -> IDLE.
// Optional macro DP_SEQ_STEP_EN gates step advance and writes with the STEP input.
module datapath_sequencer #(
    parameter int ALU_CTRL_W = 4,
    parameter int SHAMT_W    = 5,
    parameter int STEP_W     = 3
) (
    input logic                  CLK,
    input logic                  RESET_N,
    datapath_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [ALU_CTRL_W-1:0] ALU_NOT_B  = ALU_CTRL_W'(4'b1111);
    localparam logic [ALU_CTRL_W-1:0] ALU_PASS_B = ALU_CTRL_W'(4'b1101);
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD    = ALU_CTRL_W'(4'b0100);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR     = ALU_CTRL_W'(4'b1100);
    localparam logic [1:0]            SH_LSL     = 2'd0;
    localparam logic [1:0]            SH_LSR     = 2'd1;
    localparam logic [STEP_W-1:0]     ST1        = STEP_W'(1);
    localparam logic [STEP_W-1:0]     ST2        = STEP_W'(2);
    localparam logic [STEP_W-1:0]     ST3        = STEP_W'(3);

    state_t              state;
    state_t              state_d;
    logic [STEP_W-1:0]   step;
    logic [STEP_W-1:0]   step_d;
    logic [1:0]          op_q;
    logic [1:0]          op_d;
    logic                advance;

    logic                  we;
    logic                  sel0;
    logic                  sel1;
    logic                  sel2;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [1:0]            shifter_ctrl;
    logic [SHAMT_W-1:0]    shamt;
    logic                  reg_clr;

    function automatic logic [STEP_W-1:0] last_step(input logic [1:0] op);
        case (op)
            2'd0:    return ST2;
            2'd1:    return ST3;
            2'd2:    return ST3;
            default: return ST1;
        endcase
    endfunction

`ifdef DP_SEQ_STEP_EN
    assign advance = bus.STEP;
`else
    assign advance = 1'b1;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
            step  <= '0;
            op_q  <= 2'd0;
        end else begin
            state <= state_d;
            step  <= step_d;
            op_q  <= op_d;
        end
    end

    always_comb begin
        state_d = state;
        step_d  = step;
        op_d    = op_q;
        case (state)
            S_IDLE: begin
                if (bus.START) begin
                    op_d    = bus.OP;
                    step_d  = ST1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (advance) begin
                    // The comparison is >= so a corrupted step can never run past N.
                    if (step >= last_step(op_q)) begin
                        state_d = S_FIN;
                        step_d  = '0;
                    end else begin
                        step_d = step + 1'b1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                step_d  = '0;
            end
        endcase
    end

    // Every control is re-decoded each cycle from (op_q, step); nothing is held.
    always_comb begin
        we           = 1'b0;
        sel0         = 1'b0;
        sel1         = 1'b0;
        sel2         = 1'b0;
        alu_ctrl     = '0;
        shifter_ctrl = SH_LSL;
        shamt        = '0;
        reg_clr      = 1'b0;
        if (state == S_EXEC) begin
            case (op_q)
                2'd0: begin
                    if (step == ST1) begin
                        sel0     = 1'b1;
                        alu_ctrl = ALU_NOT_B;
                        we       = 1'b1;
                    end else if (step == ST2) begin
                        sel1     = 1'b1;
                        sel2     = 1'b1;
                        alu_ctrl = ALU_ADD;
                        we       = 1'b1;
                    end
                end
                2'd1: begin
                    if (step == ST1) begin
                        sel0     = 1'b1;
                        alu_ctrl = ALU_PASS_B;
                        we       = 1'b1;
                    end else if (step == ST2) begin
                        shamt    = SHAMT_W'(3);
                        alu_ctrl = ALU_ADD;
                        we       = 1'b1;
                    end else if (step == ST3) begin
                        sel0     = 1'b1;
                        alu_ctrl = ALU_ADD;
                        we       = 1'b1;
                    end
                end
                2'd2: begin
                    if (step == ST1) begin
                        sel0     = 1'b1;
                        alu_ctrl = ALU_PASS_B;
                        we       = 1'b1;
                    end else if (step == ST2) begin
                        shifter_ctrl = SH_LSR;
                        shamt        = SHAMT_W'(4);
                        alu_ctrl     = ALU_PASS_B;
                        we           = 1'b1;
                    end else if (step == ST3) begin
                        shamt    = SHAMT_W'(4);
                        alu_ctrl = ALU_OR;
                        we       = 1'b1;
                    end
                end
                default: begin
                    if (step == ST1) begin
                        reg_clr = 1'b1;
                    end
                end
            endcase
            if (!advance) begin
                we      = 1'b0;
                reg_clr = 1'b0;
            end
        end
    end

    assign bus.WE           = we;
    assign bus.SEL0         = sel0;
    assign bus.SEL1         = sel1;
    assign bus.SEL2         = sel2;
    assign bus.ALU_CTRL     = alu_ctrl;
    assign bus.SHIFTER_CTRL = shifter_ctrl;
    assign bus.SHAMT        = shamt;
    assign bus.REG_CLR      = reg_clr;
    assign bus.BUSY         = (state == S_EXEC);
    assign bus.DONE         = (state == S_FIN);
    assign bus.CYCLE        = (state == S_EXEC) ? step : '0;
    assign bus.fsm_state    = state;

`ifndef SYNTHESIS
    a_busy_done_excl: assert property (@(posedge CLK) disable iff (!RESET_N)
        !(bus.BUSY && bus.DONE));
    a_step_range: assert property (@(posedge CLK) disable iff (!RESET_N)
        (state == S_EXEC) |-> (step >= ST1 && step <= last_step(op_q)));
    a_fin_one_cycle: assert property (@(posedge CLK) disable iff (!RESET_N)
        (state == S_FIN) |=> (state == S_IDLE));
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: a behavioural datapath plus an arithmetic reference model of each OP.
// DP_SEQ_STEP_EN adds a STEP stall scenario.
module tb_datapath_sequencer;

    localparam int ALU_CTRL_W = 4;
    localparam int SHAMT_W    = 5;
    localparam int STEP_W     = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    datapath_sequencer_if #(.ALU_CTRL_W(ALU_CTRL_W), .SHAMT_W(SHAMT_W), .STEP_W(STEP_W)) bus ();

    datapath_sequencer #(.ALU_CTRL_W(ALU_CTRL_W), .SHAMT_W(SHAMT_W), .STEP_W(STEP_W)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural 8-bit datapath driven by the DUT controls.
    logic [7:0]  inp;
    logic [7:0]  dp_reg;
    logic [7:0]  a_val;
    logic [7:0]  b_val;
    logic [7:0]  sh_val;
    logic [7:0]  alu_val;
    logic [31:0] ctrl_vec;
    logic [31:0] all_vec;
    logic        step_ok;

    always_comb begin
        sh_val = (bus.SHIFTER_CTRL == 2'd1) ? (dp_reg >> bus.SHAMT) : (dp_reg << bus.SHAMT);
        a_val  = bus.SEL1 ? {7'd0, bus.SEL2} : dp_reg;
        b_val  = bus.SEL0 ? inp : sh_val;
        case (bus.ALU_CTRL)
            4'b1111: alu_val = ~b_val;
            4'b1101: alu_val = b_val;
            4'b0100: alu_val = a_val + b_val;
            4'b1100: alu_val = a_val | b_val;
            default: alu_val = 8'h00;
        endcase
        ctrl_vec = 32'({bus.WE, bus.SEL0, bus.SEL1, bus.SEL2, bus.ALU_CTRL,
                        bus.SHIFTER_CTRL, bus.SHAMT, bus.REG_CLR});
        all_vec  = 32'({bus.BUSY, bus.DONE, bus.CYCLE, ctrl_vec[15:0]});
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           dp_reg <= 8'h00;
        else if (bus.REG_CLR) dp_reg <= 8'h00;
        else if (bus.WE)      dp_reg <= alu_val;
    end

`ifdef DP_SEQ_STEP_EN
    logic step_in = 1'b1;
    assign bus.STEP = step_in;
    assign step_ok  = step_in;
`else
    assign step_ok  = 1'b1;
`endif

    // Reference model: phase 0 idle, 1..N executing, N+1 done.
    function automatic int ref_steps(input logic [1:0] op);
        case (op)
            2'd0:    return 2;
            2'd1:    return 3;
            2'd2:    return 3;
            default: return 1;
        endcase
    endfunction

    function automatic logic [7:0] ref_result(input logic [1:0] op, input logic [7:0] v);
        case (op)
            2'd0:    return 8'(0 - int'(v));
            2'd1:    return 8'(int'(v) * 10);
            2'd2:    return {v[7:4], v[7:4]};
            default: return 8'h00;
        endcase
    endfunction

    int         m_phase = 0;
    int         m_n = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_result = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_n     <= 0;
            exp_q.delete();
        end else if (m_phase == 0) begin
            if (bus.START) begin
                m_phase <= 1;
                m_n     <= ref_steps(bus.OP);
                exp_q.push_back(ref_result(bus.OP, inp));
            end
        end else if (m_phase <= m_n) begin
            if (step_ok) m_phase <= m_phase + 1;
        end else begin
            m_phase <= 0;
        end
    end

    // Scoreboard / protocol monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            automatic logic busy_e = (m_phase >= 1 && m_phase <= m_n);
            automatic logic done_e = (m_phase != 0 && m_phase == m_n + 1);
            check("busy", 32'(bus.BUSY), 32'(busy_e));
            check("done", 32'(bus.DONE), 32'(done_e));
            check("cycle", 32'(bus.CYCLE), busy_e ? 32'(m_phase) : 32'd0);
            if (!busy_e) check("idle_ctrl", ctrl_vec, 32'd0);
            if (done_e) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    automatic logic [7:0] e = exp_q.pop_front();
                    last_result = dp_reg;
                    check("result", 32'(dp_reg), 32'(e));
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_phase == 0 && !bus.BUSY && !bus.DONE) return;
        end
        check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic start_op(input logic [1:0] op, input logic [7:0] v);
        @(posedge clk);
        #1;
        bus.START = 1'b1;
        bus.OP    = op;
        inp       = v;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
        bus.OP    = 2'($urandom_range(0, 3));
    endtask

    task automatic drive_op(input logic [1:0] op, input logic [7:0] v);
        start_op(op, v);
        wait_idle();
    endtask

    task automatic wait_cycle(input logic [STEP_W-1:0] c);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.CYCLE == c) return;
        end
        check("cycle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.START = 1'b0;
        bus.OP    = 2'd0;
        inp       = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outs", all_vec, 32'd0);
        #2 rst_n = 1'b1;

        // Reset in the middle of OP1, step 2.
        start_op(2'd1, 8'h07);
        wait_cycle(STEP_W'(2));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_outs", all_vec, 32'd0);
        check("midrst_busy", 32'(bus.BUSY), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        drive_op(2'd0, 8'h05);
        check("op0_05", 32'(last_result), 32'h0FB);
        drive_op(2'd1, 8'h07);
        check("op1_07", 32'(last_result), 32'h046);
        drive_op(2'd1, 8'h1A);
        check("op1_1a", 32'(last_result), 32'h004);
        drive_op(2'd2, 8'hA5);
        check("op2_a5", 32'(last_result), 32'h0AA);
        drive_op(2'd3, 8'h5A);
        check("op3_clr", 32'(last_result), 32'h000);
        drive_op(2'd2, 8'h3C);
        check("op2_3c", 32'(last_result), 32'h033);
        drive_op(2'd0, 8'h00);
        check("op0_00", 32'(last_result), 32'h000);
        drive_op(2'd0, 8'h80);
        check("op0_80", 32'(last_result), 32'h080);

        // START held high, OP toggling every cycle: back-to-back operations.
        @(posedge clk);
        #1;
        inp       = 8'h39;
        bus.START = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus.OP = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
        end
        bus.START = 1'b0;
        wait_idle();

`ifdef DP_SEQ_STEP_EN
        start_op(2'd1, 8'h07);
        wait_cycle(STEP_W'(2));
        step_in = 1'b0;
        begin
            automatic logic [7:0] held = dp_reg;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("stall_cycle", 32'(bus.CYCLE), 32'd2);
                check("stall_we", 32'(bus.WE), 32'd0);
            end
            check("stall_reg", 32'(dp_reg), 32'(held));
        end
        step_in = 1'b1;
        wait_idle();
        check("stall_result", 32'(last_result), 32'h046);
`endif

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            drive_op(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Clocked micro-sequencer driving the control inputs of the team's 8-bit accumulator datapath (register, operand muxes, ALU, shifter). It replaces free-running cycle-count decode with a start/done handshake. It also latches the requested operation and forces every control output to a defined value in every cycle. It sits between the requester (switch/top-level logic) and the datapath; the datapath register clocks on the same CLK rising edge.

Parameters:
ALU_CTRL_W, 4, width of ALU_CTRL bus
SHAMT_W, 5, width of SHAMT bus
STEP_W, 3, width of step counter / CYCLE output

Ports:
CLK  input  1  system clock, all state on rising edge
RESET_N  input  1  asynchronous, active-low reset
START  input  1  request pulse/level, sampled only in IDLE
OP  input  2  operation code, latched when START accepted
WE  output  1  datapath register write enable
SEL0  output  1  ALU B mux: 0 shifter_out, 1 INP
SEL1  output  1  ALU A mux: 0 REG_OUT, 1 constant mux
SEL2  output  1  constant mux: 0 -> 0, 1 -> 1
ALU_CTRL  output  ALU_CTRL_W  ALU function
SHIFTER_CTRL  output  2  shifter function
SHAMT  output  SHAMT_W  shift amount
REG_CLR  output  1  synchronous clear request to datapath register
BUSY  output  1  high while executing
DONE  output  1  one-cycle pulse, result valid on REG_OUT
CYCLE  output  STEP_W  current step 1..N, 0 when not executing

Behaviour:
- Encodings: ALU 1111 = NOT B, 1101 = pass B, 0100 = A+B mod 256, 1100 = A OR B. SHIFTER_CTRL 0 = LSL, 1 = LSR.
- Reset (RESET_N low, any time incl. mid-operation): state IDLE, step 0, latched OP 0. All outputs 0. Reset takes effect immediately; no partial write completes after reset asserts.
- FSM states: IDLE -> EXEC -> FIN -> IDLE.
- IDLE: START=1 at an edge latches OP, sets step=1, enters EXEC. START=0 stays IDLE.
- EXEC: BUSY=1, CYCLE=step. Outputs decode combinationally from latched OP and step. Register writes at the edge ending each step. At the last step of an OP, go to FIN; otherwise step+1.
- FIN: DONE=1 and BUSY=0 for exactly one cycle, then IDLE. START in EXEC or FIN is ignored; no queuing. A new START is accepted on the cycle after FIN at the earliest.
- OP/START changes while BUSY have no effect. The requester holds INP stable from START acceptance until DONE.
- Default every cycle, including unused steps: WE=0, SEL*=0, ALU_CTRL=0, SHIFTER_CTRL=0, SHAMT=0, REG_CLR=0. No latched/held control values.
- OP0, 2's complement, 2 steps: s1 SEL0=1 ALU=1111 WE=1. s2 SEL0=0 SEL1=1 SEL2=1 SHIFTER=0 SHAMT=0 ALU=0100 WE=1.
- OP1, x10 mod 256, 3 steps: s1 SEL0=1 ALU=1101 WE=1. s2 SEL0=0 SEL1=0 SHIFTER=0 SHAMT=3 ALU=0100 WE=1 (9x). s3 SEL0=1 SEL1=0 ALU=0100 WE=1.
- OP2, duplicate upper nibble, 3 steps: s1 SEL0=1 ALU=1101 WE=1. s2 SEL0=0 SEL1=0 SHIFTER=1 SHAMT=4 ALU=1101 WE=1. s3 SEL0=0 SEL1=0 SHIFTER=0 SHAMT=4 ALU=1100 WE=1.
- OP3, clear, 1 step: s1 REG_CLR=1, WE=0.
- Latency: START-accept edge to DONE high = N+1 cycles (N = step count). REG_OUT holds the final result when DONE=1.
- Step counter never exceeds the OP's N; no wrap.

Optional Feature:
Macro DP_SEQ_STEP_EN.
- Defined: adds input STEP (1 bit). In EXEC, step advances and the write occurs only in cycles where STEP=1; otherwise WE and REG_CLR are forced 0 and state holds, with other controls still decoded. IDLE/FIN are unaffected.
- Undefined: no STEP port; the sequencer advances every cycle.

Test Plan:
- Reset mid-OP1 at step 2 -> all outputs 0 immediately, BUSY=0. After release, START with OP0 completes normally.
- OP0, INP=0x05 -> BUSY for 2 cycles, DONE at cycle 3, REG_OUT=0xFB. CYCLE sequence 1,2,0.
- OP1, INP=0x07 -> REG_OUT=0x46. OP1 with INP=0x1A -> 0x04 (wrap). DONE at cycle 4.
- OP2, INP=0xA5 -> REG_OUT=0xAA. OP2 with INP=0x3C -> 0x33.
- START held high continuously with OP toggling -> back-to-back ops, one idle cycle between FIN and next EXEC. OP changes during BUSY do not alter the result.
- OP3 after any result -> REG_CLR pulse in step 1, REG_OUT=0x00 at DONE (cycle 2). With DP_SEQ_STEP_EN: STEP=0 for 5 cycles in OP1 s2 -> no writes, CYCLE stays 2.
